alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Multi-cycle controller that shares the single 19-bit ALU between two requesters (r0, r1).
- Arbitrates requests round-robin and registers operands/opcode onto the ALU ports.
- Holds the operands stable for a per-opcode number of cycles, because the combinational MULT and DIV/MOD paths are slow.
- Captures result and flags, then returns them through a single valid/ready response channel.

Parameters:
- N, 19, datapath width of operands and result.
- MUL_CYCLES, 2, EXEC cycles for op 3'b010 (MULT); must be >=1.
- DIV_CYCLES, 4, EXEC cycles for ops 3'b011 (DIV) and 3'b100 (MOD); must be >=1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_valid  in  1  requester 0 has an operation.
- r0_ready  out  1  requester 0 accepted this cycle when r0_valid&r0_ready.
- r0_a, r0_b  in  N  requester 0 operands.
- r0_op  in  3  requester 0 ALU opcode (ALUControl encoding).
- r1_valid, r1_ready, r1_a, r1_b, r1_op: same as r0 for requester 1.
- alu_a, alu_b  out  N  registered operands to the ALU.
- alu_ctrl  out  3  registered opcode to the ALU.
- alu_result  in  N  ALU Result.
- alu_flags  in  3  ALU flags {Z,O,N}.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp_id  out  1  requester index the response belongs to.
- resp_result  out  N  captured result.
- resp_flags  out  3  captured flags {Z,O,N}.
- resp_err  out  1  divide-by-zero indication.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async): state=IDLE; alu_a/alu_b/alu_ctrl=0; resp_valid=0; resp_id/resp_result/resp_flags/resp_err=0; cycle counter=0; last_grant=1, so r0 wins the first tie. An in-flight operation is discarded and resp_valid drops immediately.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant (combinational, IDLE only):
  - Exactly one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - rX_ready=1 only for the granted requester. Both readys are 0 in EXEC/RESP.
- IDLE, acceptance (rX_valid&rX_ready at edge t):
  - Latch rX_a/rX_b/rX_op into alu_a/alu_b/alu_ctrl; latch id; set last_grant=X.
  - If op is 3'b011 or 3'b100 and rX_b==0: go to RESP with resp_err=1, resp_result=0, resp_flags=3'b100, with no EXEC. resp_valid=1 from t+1.
  - Otherwise load counter with L-1 and go to EXEC. L=MUL_CYCLES for 3'b010, DIV_CYCLES for 3'b011/3'b100, 1 for all other opcodes.
- EXEC:
  - alu_a/alu_b/alu_ctrl stay constant.
  - Counter decrements each cycle.
  - When counter==0 at an edge: capture alu_result→resp_result and alu_flags→resp_flags, set resp_err=0, go to RESP.
- Latency: for a request accepted at edge t, resp_valid rises after edge t+L+1. Example: an ADD accepted at cycle 0 is visible as resp_valid in cycle 2.
- RESP:
  - resp_* held stable while resp_valid=1 and !resp_ready.
  - On resp_valid&resp_ready: resp_valid=0, go to IDLE. No new grant in the same cycle, so the minimum spacing between acceptances is L+2 cycles.
- alu_* hold their last values in IDLE; they are only reloaded on acceptance.
- Result width is N bits. Overflow/truncation is the ALU's; the controller performs no arithmetic on data.
- A requester dropping valid before acceptance is legal and has no effect. Operands are sampled only at the acceptance edge.
- Opcodes 3'b101/110/111 are single-cycle like SUM/RES.

Test Plan:
- Reset mid-DIV: r0 DIV A=100,B=7 accepted, reset asserted during cycle 2 of EXEC → busy=0, resp_valid=0 asynchronously; after release r0_ready=1 in IDLE; no response ever emitted for the dropped op.
- Single ADD: r0 SUM A=5,B=3, resp_ready=1 → r0_ready=1 at cycle 0; resp_valid at cycle 2 with resp_id=0, resp_result=8, resp_flags=3'b000, resp_err=0; busy high cycles 1-2.
- DIV/MOD latency: r1 DIV A=100,B=7 then MOD A=100,B=7 (DIV_CYCLES=4) → alu_a/b/ctrl stable 4 EXEC cycles; resp_result=14 at cycle 5, then 2, both with resp_id=1.
- Divide by zero: r0 MOD A=9,B=0 → resp_valid at cycle 1, resp_err=1, resp_result=0, resp_flags=3'b100; alu_ctrl=3'b100 loaded, no EXEC.
- Round-robin and backpressure: r0 and r1 both valid continuously with SUB ops; resp_ready low 3 cycles per response → grants alternate 0,1,0,1; resp_* stable while stalled; no ready pulse outside IDLE.
- MULT: r1 MULT A=300,B=200 (MUL_CYCLES=2) → response at cycle 3, resp_result=60000 mod 2^19=60000, flags match ALU output sampled at the end of EXEC.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin controller sharing one combinational ALU between two requesters.
// Operands are held on the ALU for a per-opcode number of cycles, then the result is returned.
module alu_arbiter #(
   parameter int unsigned N          = 19,
   parameter int unsigned MUL_CYCLES = 2,
   parameter int unsigned DIV_CYCLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         r0_valid,
   output logic         r0_ready,
   input  logic [N-1:0] r0_a,
   input  logic [N-1:0] r0_b,
   input  logic [2:0]   r0_op,
   input  logic         r1_valid,
   output logic         r1_ready,
   input  logic [N-1:0] r1_a,
   input  logic [N-1:0] r1_b,
   input  logic [2:0]   r1_op,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [2:0]   alu_ctrl,
   input  logic [N-1:0] alu_result,
   input  logic [2:0]   alu_flags,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic         resp_id,
   output logic [N-1:0] resp_result,
   output logic [2:0]   resp_flags,
   output logic         resp_err,
   output logic         busy
);

   localparam int unsigned MaxL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CW   = (MaxL > 1) ? $clog2(MaxL) : 1;

   localparam logic [2:0] OpMul = 3'b010;
   localparam logic [2:0] OpDiv = 3'b011;
   localparam logic [2:0] OpMod = 3'b100;

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            last_grant_q;

   logic            gnt_valid;
   logic            gnt_id;
   logic [N-1:0]    sel_a, sel_b;
   logic [2:0]      sel_op;
   logic [CW-1:0]   lat_m1;
   logic            div_zero;
   logic            accept;
   logic            capture;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      gnt_id = 1'b0;
      if (r0_valid && r1_valid) begin
         gnt_id = ~last_grant_q;
      end else if (r1_valid) begin
         gnt_id = 1'b1;
      end
      gnt_valid = (state_q == StIdle) && (r0_valid || r1_valid);
      r0_ready  = gnt_valid && !gnt_id;
      r1_ready  = gnt_valid && gnt_id;
   end

   assign sel_a    = gnt_id ? r1_a  : r0_a;
   assign sel_b    = gnt_id ? r1_b  : r0_b;
   assign sel_op   = gnt_id ? r1_op : r0_op;
   assign div_zero = ((sel_op == OpDiv) || (sel_op == OpMod)) && (sel_b == '0);

   always_comb begin
      lat_m1 = '0;
      if (sel_op == OpMul) begin
         lat_m1 = CW'(MUL_CYCLES - 1);
      end else if ((sel_op == OpDiv) || (sel_op == OpMod)) begin
         lat_m1 = CW'(DIV_CYCLES - 1);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (gnt_valid) begin
               accept = 1'b1;
               if (div_zero) begin
                  state_d = StResp;
               end else begin
                  state_d = StExec;
                  cnt_d   = lat_m1;
               end
            end
         end
         StExec: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         StResp: begin
            if (resp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a        <= '0;
         alu_b        <= '0;
         alu_ctrl     <= '0;
         last_grant_q <= 1'b1;
         resp_id      <= 1'b0;
         resp_result  <= '0;
         resp_flags   <= '0;
         resp_err     <= 1'b0;
      end else if (accept) begin
         alu_a        <= sel_a;
         alu_b        <= sel_b;
         alu_ctrl     <= sel_op;
         last_grant_q <= gnt_id;
         resp_id      <= gnt_id;
         if (div_zero) begin
            resp_err    <= 1'b1;
            resp_result <= '0;
            resp_flags  <= 3'b100;
         end
      end else if (capture) begin
         resp_result <= alu_result;
         resp_flags  <= alu_flags;
         resp_err    <= 1'b0;
      end
   end

   assign resp_valid = (state_q == StResp);
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU driving alu_result/alu_flags.
module tb_alu_arbiter;

   localparam int unsigned N = 19;

   logic         clk;
   logic         reset;
   logic         r0_valid, r0_ready, r1_valid, r1_ready;
   logic [N-1:0] r0_a, r0_b, r1_a, r1_b;
   logic [2:0]   r0_op, r1_op;
   logic [N-1:0] alu_a, alu_b, alu_result;
   logic [2:0]   alu_ctrl, alu_flags;
   logic         resp_valid, resp_ready, resp_id, resp_err, busy;
   logic [N-1:0] resp_result;
   logic [2:0]   resp_flags;

   int n_cmp  = 0;
   int n_fail = 0;

   alu_arbiter #(.N(N), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .r0_valid    (r0_valid),
      .r0_ready    (r0_ready),
      .r0_a        (r0_a),
      .r0_b        (r0_b),
      .r0_op       (r0_op),
      .r1_valid    (r1_valid),
      .r1_ready    (r1_ready),
      .r1_a        (r1_a),
      .r1_b        (r1_b),
      .r1_op       (r1_op),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_ctrl    (alu_ctrl),
      .alu_result  (alu_result),
      .alu_flags   (alu_flags),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .resp_flags  (resp_flags),
      .resp_err    (resp_err),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stand-in; flags are {Z,O,N} with O set on multiply overflow.
   logic [2*N-1:0] prod;
   always_comb begin
      prod       = {{N{1'b0}}, alu_a} * {{N{1'b0}}, alu_b};
      alu_result = '0;
      case (alu_ctrl)
         3'b000:  alu_result = alu_a + alu_b;
         3'b001:  alu_result = alu_a - alu_b;
         3'b010:  alu_result = prod[N-1:0];
         3'b011:  alu_result = (alu_b != '0) ? alu_a / alu_b : '0;
         3'b100:  alu_result = (alu_b != '0) ? alu_a % alu_b : '0;
         3'b101:  alu_result = alu_a & alu_b;
         3'b110:  alu_result = alu_a | alu_b;
         default: alu_result = alu_a ^ alu_b;
      endcase
      alu_flags = {alu_result == '0, (alu_ctrl == 3'b010) && (prod[2*N-1:N] != '0),
                   alu_result[N-1]};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_op = '0;
      r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0;
      resp_ready = 1'b0;
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_resp_result", resp_result, 0);
      tick();
      reset = 1'b0;

      // Reset in the middle of a DIV: the op is dropped without a response.
      r0_valid = 1'b1; r0_a = 100; r0_b = 7; r0_op = 3'b011;
      #1;
      chk("div0_r0_ready", r0_ready, 1);
      tick();
      r0_valid = 1'b0;
      chk("div0_busy_c1", busy, 1);
      tick();
      chk("div0_alu_ctrl_c2", alu_ctrl, 3'b011);
      reset = 1'b1;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_resp_valid", resp_valid, 0);
      chk("async_rst_alu_ctrl", alu_ctrl, 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("post_rst_no_resp", resp_valid, 0);
         tick();
      end

      // Single ADD from r0.
      resp_ready = 1'b1;
      r0_valid = 1'b1; r0_a = 5; r0_b = 3; r0_op = 3'b000;
      #1;
      chk("add_r0_ready", r0_ready, 1);
      chk("add_r1_ready", r1_ready, 0);
      chk("add_busy_c0", busy, 0);
      tick();
      r0_valid = 1'b0;
      chk("add_busy_c1", busy, 1);
      chk("add_alu_a", alu_a, 5);
      chk("add_alu_b", alu_b, 3);
      chk("add_resp_valid_c1", resp_valid, 0);
      tick();
      chk("add_resp_valid_c2", resp_valid, 1);
      chk("add_resp_id", resp_id, 0);
      chk("add_resp_result", resp_result, 8);
      chk("add_resp_flags", resp_flags, 3'b000);
      chk("add_resp_err", resp_err, 0);
      chk("add_busy_c2", busy, 1);
      tick();
      chk("add_resp_done", resp_valid, 0);
      chk("add_busy_c3", busy, 0);

      // r1 DIV then MOD, both 100/7.
      r1_valid = 1'b1; r1_a = 100; r1_b = 7; r1_op = 3'b011;
      #1;
      chk("div_r1_ready", r1_ready, 1);
      chk("div_r0_ready", r0_ready, 0);
      tick();
      r1_op = 3'b100;
      for (int i = 0; i < 4; i++) begin
         chk("div_exec_ctrl", alu_ctrl, 3'b011);
         chk("div_exec_a", alu_a, 100);
         chk("div_exec_b", alu_b, 7);
         chk("div_exec_noresp", resp_valid, 0);
         chk("div_exec_r1_ready", r1_ready, 0);
         tick();
      end
      chk("div_resp_valid", resp_valid, 1);
      chk("div_resp_result", resp_result, 14);
      chk("div_resp_id", resp_id, 1);
      chk("div_resp_err", resp_err, 0);
      tick();
      chk("mod_resp_cleared", resp_valid, 0);
      chk("mod_r1_ready", r1_ready, 1);
      tick();
      r1_valid = 1'b0;
      chk("mod_alu_ctrl", alu_ctrl, 3'b100);
      tick(); tick(); tick();
      chk("mod_exec4_noresp", resp_valid, 0);
      tick();
      chk("mod_resp_valid", resp_valid, 1);
      chk("mod_resp_result", resp_result, 2);
      chk("mod_resp_id", resp_id, 1);
      tick();

      // Round robin with both requesters valid and 3 stalled response cycles each.
      resp_ready = 1'b0;
      r0_valid = 1'b1; r0_a = 10; r0_b = 3;  r0_op = 3'b001;
      r1_valid = 1'b1; r1_a = 3;  r1_b = 10; r1_op = 3'b001;
      for (int k = 0; k < 4; k++) begin
         logic         g;
         logic [N-1:0] exp_res;
         logic [2:0]   exp_flg;
         g       = k[0];
         exp_res = g ? 19'h7FFF9 : 19'd7;
         exp_flg = g ? 3'b001 : 3'b000;
         #1;
         chk("rr_r0_ready", r0_ready, !g);
         chk("rr_r1_ready", r1_ready, g);
         tick();
         chk("rr_exec_r0_ready", r0_ready, 0);
         chk("rr_exec_r1_ready", r1_ready, 0);
         tick();
         for (int s = 0; s < 3; s++) begin
            chk("rr_stall_valid", resp_valid, 1);
            chk("rr_stall_id", resp_id, g);
            chk("rr_stall_result", resp_result, exp_res);
            chk("rr_stall_flags", resp_flags, exp_flg);
            chk("rr_stall_rdy", r0_ready | r1_ready, 0);
            tick();
         end
         chk("rr_final_valid", resp_valid, 1);
         chk("rr_final_result", resp_result, exp_res);
         resp_ready = 1'b1;
         tick();
         resp_ready = 1'b0;
         chk("rr_idle_after", resp_valid, 0);
      end
      r0_valid = 1'b0;
      r1_valid = 1'b0;

      // Divide by zero skips EXEC.
      resp_ready = 1'b1;
      tick();
      r0_valid = 1'b1; r0_a = 9; r0_b = 0; r0_op = 3'b100;
      #1;
      chk("dz_r0_ready", r0_ready, 1);
      tick();
      r0_valid = 1'b0;
      chk("dz_resp_valid", resp_valid, 1);
      chk("dz_resp_err", resp_err, 1);
      chk("dz_resp_result", resp_result, 0);
      chk("dz_resp_flags", resp_flags, 3'b100);
      chk("dz_alu_ctrl", alu_ctrl, 3'b100);
      chk("dz_resp_id", resp_id, 0);
      tick();
      chk("dz_idle", busy, 0);

      // MULT from r1.
      r1_valid = 1'b1; r1_a = 300; r1_b = 200; r1_op = 3'b010;
      #1;
      chk("mul_r1_ready", r1_ready, 1);
      tick();
      r1_valid = 1'b0;
      chk("mul_alu_ctrl", alu_ctrl, 3'b010);
      tick();
      chk("mul_c2_noresp", resp_valid, 0);
      chk("mul_c2_alu_a", alu_a, 300);
      tick();
      chk("mul_resp_valid", resp_valid, 1);
      chk("mul_resp_result", resp_result, 60000);
      chk("mul_resp_flags", resp_flags, 3'b000);
      chk("mul_resp_id", resp_id, 1);
      chk("mul_resp_err", resp_err, 0);
      tick();
      chk("mul_done", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
